// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a tri-state read port and ready/overrun/framing flags
module uart_rx #(
  parameter int ClksPerBit = 16
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_bar,
  output logic [7:0] dataout,
  output logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_ferr
);
  localparam int CW = $clog2(ClksPerBit);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  state_t          state;
  logic [CW-1:0]   bcnt;
  logic [2:0]      bidx;
  logic [7:0]      shift, hold;
  logic            s1, rxs;
  logic            rd, bit_end;
  assign rd      = !rd_bar;
  assign bit_end = bcnt == '0;
  assign dataout = rd ? hold : 8'bz;
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      bidx       <= '0;
      shift      <= 8'h00;
      hold       <= 8'h00;
      rx_ready   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
      s1         <= 1'b1;
      rxs        <= 1'b1;
    end else begin
      s1  <= rxd;
      rxs <= s1;
      if (rd) begin
        rx_ready   <= 1'b0;
        rx_overrun <= 1'b0;
        rx_ferr    <= 1'b0;
      end
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          bcnt  <= CW'(ClksPerBit / 2 - 1);
        end
        START: if (!bit_end) bcnt <= bcnt - 1'b1;
          else if (rxs) state <= IDLE;
          else begin
            state <= DATA;
            bidx  <= '0;
            bcnt  <= CW'(ClksPerBit - 1);
          end
        DATA: if (!bit_end) bcnt <= bcnt - 1'b1;
          else begin
            shift <= {rxs, shift[7:1]};
            bcnt  <= CW'(ClksPerBit - 1);
            bidx  <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end
        STOP: if (!bit_end) bcnt <= bcnt - 1'b1;
          else if (!rxs) begin
            rx_ferr <= 1'b1;
            state   <= WAITHI;
          end else begin
            state <= IDLE;
            // a read on this same edge frees the register, so the new byte wins
            if (rx_ready && !rd) rx_overrun <= 1'b1;
            else begin
              hold     <= shift;
              rx_ready <= 1'b1;
            end
          end
        WAITHI: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 4 clocks per bit
module tb_uart_rx;
  localparam int CPB = 4;
  logic       clk = 1'b0;
  logic       reset, rxd, rd_bar;
  logic [7:0] dataout;
  logic       rx_ready, rx_overrun, rx_ferr;
  int         checks = 0, failures = 0;
  logic [7:0] sb[$];
  uart_rx #(.ClksPerBit(CPB)) dut (
    .i_clk(clk), .reset(reset), .rxd(rxd), .rd_bar(rd_bar),
    .dataout(dataout), .rx_ready(rx_ready), .rx_overrun(rx_overrun), .rx_ferr(rx_ferr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic bit_out(input logic v);
    rxd = v;
    tick(CPB);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(stop);
  endtask
  task automatic read_byte(input string tag);
    logic [7:0] exp;
    rd_bar = 1'b0;
    #1;
    if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else begin
      exp = sb.pop_front();
      check({tag, "_data"}, dataout, exp);
    end
    @(posedge clk);
    #1;
    rd_bar = 1'b1;
    check({tag, "_ready_clr"}, rx_ready, 0);
    check({tag, "_ovr_clr"}, rx_overrun, 0);
    check({tag, "_ferr_clr"}, rx_ferr, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0; rxd = 1'b1; rd_bar = 1'b1;
    tick(3);
    check("rst_ready", rx_ready, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_ferr", rx_ferr, 0);
    reset = 1'b1;
    tick(2);
    sb.push_back(8'h00);
    read_byte("rst_read");
    // single byte with exact ready timing: stop sample is the edge after send returns
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    check("a5_ready_early", rx_ready, 0);
    tick(1);
    check("a5_ready", rx_ready, 1);
    read_byte("a5");
    // overrun: second byte dropped, first kept
    sb.push_back(8'h41);
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    tick(1);
    check("ovr_set", rx_overrun, 1);
    check("ovr_ready", rx_ready, 1);
    read_byte("ovr");
    // read landing on the second stop-sample edge
    sb.push_back(8'h41);
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    rd_bar = 1'b0;
    #1;
    check("race_data", dataout, sb.pop_front());
    tick(1);
    rd_bar = 1'b1;
    check("race_ready", rx_ready, 1);
    check("race_ovr", rx_overrun, 0);
    sb.push_back(8'h42);
    read_byte("race_new");
    // framing error followed by a held break
    send(8'h77, 1'b0);
    tick(1);
    check("ferr_set", rx_ferr, 1);
    check("ferr_ready", rx_ready, 0);
    rd_bar = 1'b0;
    tick(1);
    rd_bar = 1'b1;
    check("ferr_clr", rx_ferr, 0);
    tick(38);
    check("brk_ferr_once", rx_ferr, 0);
    check("brk_ready", rx_ready, 0);
    rxd = 1'b1;
    tick(20);
    check("brk_end_ferr", rx_ferr, 0);
    check("brk_end_ready", rx_ready, 0);
    // one-cycle glitch is rejected as a false start
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    check("glitch_ready", rx_ready, 0);
    check("glitch_idle", 32'(dut.state), 0);
    sb.push_back(8'h5A);
    send(8'h5A, 1'b1);
    tick(1);
    check("post_glitch_ready", rx_ready, 1);
    read_byte("post_glitch");
    // reset during data bit 3 abandons the frame
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rxd = 1'b0;
    tick(2);
    reset = 1'b0;
    rxd = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("midrst_ready", rx_ready, 0);
    check("midrst_ovr", rx_overrun, 0);
    check("midrst_ferr", rx_ferr, 0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1);
    tick(1);
    check("midrst_3c_ready", rx_ready, 1);
    read_byte("midrst_3c");
    // back-to-back frames with a concurrent reader
    fork
      begin
        sb.push_back(8'h00); send(8'h00, 1'b1);
        sb.push_back(8'hFF); send(8'hFF, 1'b1);
        sb.push_back(8'h55); send(8'h55, 1'b1);
        rxd = 1'b1;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int n = 0;
          while (!rx_ready && n < 200) begin
            tick(1);
            n++;
          end
          if (n >= 200) check("b2b_timeout", 0, 1);
          else read_byte("b2b");
        end
      end
    join
    check("b2b_sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
